// File: rtl/m_frame_encoder.sv
// Frame encoder: turns a latched CMD/PARA request into a 0x40,LEN,CMD,PARA..,CHECK byte stream
// and feeds it to a UART transmitter one byte per i_tx_done handshake.
module m_frame_encoder #(
    parameter logic [7:0]  FRAME_HEADER = 8'h40,
    parameter logic [7:0]  FRAME_TAIL   = 8'hbc,
    parameter bit          CHECK_XOR    = 1'b0,
    parameter int unsigned TIMEOUT_CYC  = 200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_send_en,
    input  logic [7:0]  i_cmdcode,
    input  logic [31:0] i_para_list,
    input  logic [2:0]  i_para_num,
    input  logic        i_tx_done,
    output logic        o_tx_en,
    output logic [7:0]  o_tx_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam bit          TimeoutEn   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TimeoutLast = TIMEOUT_CYC - 32'd1;

    typedef enum logic [1:0] {StIdle, StSend, StWait, StDone} state_e;

    state_e      state_q;
    logic [7:0]  cmd_q;
    logic [31:0] para_q;
    logic [2:0]  num_q;
    logic [2:0]  idx_q;
    logic [31:0] timer_q;

    logic [2:0]  last_idx;
    logic [2:0]  nxt_idx;
    logic [1:0]  para_sel;
    logic [7:0]  len_byte;
    logic [7:0]  chk_byte;
    logic [7:0]  nxt_byte;

    // num_q is clamped to 4, so the CHECK index never exceeds 7.
    assign last_idx = num_q + 3'd3;
    assign nxt_idx  = idx_q + 3'd1;
    assign para_sel = 2'(nxt_idx - 3'd3);
    assign len_byte = {5'd0, num_q} + 8'd1;

    always_comb begin
        chk_byte = len_byte ^ cmd_q;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < num_q) begin
                chk_byte = chk_byte ^ para_q[8*k +: 8];
            end
        end
    end

    // Byte that follows the one currently in flight; header is loaded directly on accept.
    always_comb begin
        nxt_byte = 8'h00;
        if (nxt_idx == last_idx) begin
            nxt_byte = CHECK_XOR ? chk_byte : FRAME_TAIL;
        end else if (nxt_idx == 3'd1) begin
            nxt_byte = len_byte;
        end else if (nxt_idx == 3'd2) begin
            nxt_byte = cmd_q;
        end else begin
            nxt_byte = para_q[{para_sel, 3'b000} +: 8];
        end
    end

    assign o_busy = (state_q == StSend) || (state_q == StWait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cmd_q     <= 8'h00;
            para_q    <= 32'h0;
            num_q     <= 3'd0;
            idx_q     <= 3'd0;
            timer_q   <= 32'h0;
            o_tx_en   <= 1'b0;
            o_tx_data <= 8'h00;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_tx_en <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (i_send_en) begin
                        cmd_q     <= i_cmdcode;
                        para_q    <= i_para_list;
                        num_q     <= (i_para_num > 3'd4) ? 3'd4 : i_para_num;
                        idx_q     <= 3'd0;
                        o_tx_en   <= 1'b1;
                        o_tx_data <= FRAME_HEADER;
                        state_q   <= StSend;
                    end
                end
                StSend: begin
                    timer_q <= 32'h0;
                    state_q <= StWait;
                end
                StWait: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (i_tx_done) begin
                        if (idx_q == last_idx) begin
                            o_done  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q     <= nxt_idx;
                            o_tx_en   <= 1'b1;
                            o_tx_data <= nxt_byte;
                            state_q   <= StSend;
                        end
                    end else if (TimeoutEn && (timer_q == TimeoutLast)) begin
                        o_err   <= 1'b1;
                        state_q <= StIdle;
                    end else if (timer_q != 32'hffff_ffff) begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_frame_encoder.sv
// Bench for m_frame_encoder: DUT0 uses a fixed tail and a 50-cycle timeout, DUT1 uses the XOR
// checksum with no timeout. Expected bytes/events are queued per DUT and popped as they appear.
module tb_m_frame_encoder;

    localparam int Delay   = 10;
    localparam int ToCyc   = 50;
    localparam int TokDone = 256;
    localparam int TokErr  = 257;
    localparam int TokNone = 999;
    localparam int Ignore  = 0;
    localparam int Full    = 1;
    localparam int AccOnly = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]       send_en;
    logic [1:0][7:0]  cmdcode;
    logic [1:0][31:0] para_list;
    logic [1:0][2:0]  para_num;
    logic [1:0]       tx_done = 2'b00;
    wire  [1:0]       tx_en;
    wire  [1:0][7:0]  tx_data;
    wire  [1:0]       busy;
    wire  [1:0]       done;
    wire  [1:0]       err;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int trig [2];
    int cnt [2];
    int nstrobe [2];
    int limit [2];
    int last_strobe [2];
    int q0 [$];
    int q1 [$];

    m_frame_encoder #(
        .FRAME_HEADER(8'h40),
        .FRAME_TAIL  (8'hbc),
        .CHECK_XOR   (1'b0),
        .TIMEOUT_CYC (ToCyc)
    ) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_send_en  (send_en[0]),
        .i_cmdcode  (cmdcode[0]),
        .i_para_list(para_list[0]),
        .i_para_num (para_num[0]),
        .i_tx_done  (tx_done[0]),
        .o_tx_en    (tx_en[0]),
        .o_tx_data  (tx_data[0]),
        .o_busy     (busy[0]),
        .o_done     (done[0]),
        .o_err      (err[0])
    );

    m_frame_encoder #(
        .FRAME_HEADER(8'h40),
        .FRAME_TAIL  (8'hbc),
        .CHECK_XOR   (1'b1),
        .TIMEOUT_CYC (0)
    ) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_send_en  (send_en[1]),
        .i_cmdcode  (cmdcode[1]),
        .i_para_list(para_list[1]),
        .i_para_num (para_num[1]),
        .i_tx_done  (tx_done[1]),
        .o_tx_en    (tx_en[1]),
        .o_tx_data  (tx_data[1]),
        .o_busy     (busy[1]),
        .o_done     (done[1]),
        .o_err      (err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int i, input int v);
        if (i == 0) q0.push_back(v);
        else q1.push_back(v);
    endfunction

    function automatic int pop(input int i);
        int v;
        v = TokNone;
        if (i == 0) begin
            if (q0.size() > 0) v = q0.pop_front();
        end else if (q1.size() > 0) begin
            v = q1.pop_front();
        end
        return v;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // Reference frame: header, LEN, CMD, clamped PARA bytes LSB first, CHECK, then done.
    task automatic push_frame(input int i, input logic [7:0] c, input logic [31:0] p,
                              input int n_raw, input bit use_xor);
        int n;
        logic [7:0] len;
        logic [7:0] x;
        logic [7:0] b;
        n = (n_raw > 4) ? 4 : n_raw;
        len = 8'(n + 1);
        x = len ^ c;
        push(i, 32'h40);
        push(i, int'(len));
        push(i, int'(c));
        for (int k = 0; k < n; k++) begin
            b = p[8*k +: 8];
            push(i, int'(b));
            x = x ^ b;
        end
        push(i, use_xor ? int'(x) : 32'hbc);
        push(i, TokDone);
    endtask

    task automatic send(input int i, input logic [7:0] c, input logic [31:0] p,
                        input logic [2:0] n, input int mode);
        @(negedge clk);
        send_en[i]   = 1'b1;
        cmdcode[i]   = c;
        para_list[i] = p;
        para_num[i]  = n;
        if (mode == Full) push_frame(i, c, p, int'(n), (i == 1));
        if (mode != Ignore) begin
            trig[i]    = cyc;
            nstrobe[i] = 0;
        end
        @(negedge clk);
        send_en[i]   = 1'b0;
        cmdcode[i]   = ~c;
        para_list[i] = ~p;
        para_num[i]  = 3'd1;
    endtask

    task automatic wait_frame(input int i);
        int n;
        n = 0;
        while ((qsize(i) != 0 || busy[i]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("frame_drained", qsize(i), 0);
        check("idle_busy", 32'(busy[i]), 0);
    endtask

    // Monitor first, then the UART model, so a strobe is checked before trig moves on.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            tx_done[i] = 1'b0;
            if (!rst_n) begin
                cnt[i] = 0;
            end else begin
                if (tx_en[i]) begin
                    check("tx_byte", 32'(tx_data[i]), pop(i));
                    check("strobe_latency", cyc - trig[i], 1);
                    nstrobe[i]++;
                    last_strobe[i] = cyc;
                    if (limit[i] == 0 || nstrobe[i] <= limit[i]) cnt[i] = Delay;
                end else if (cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        tx_done[i] = 1'b1;
                        trig[i] = cyc;
                    end
                end
                if (done[i]) begin
                    check("done_event", TokDone, pop(i));
                    check("done_latency", cyc - trig[i], 1);
                end
                if (err[i]) begin
                    check("err_event", TokErr, pop(i));
                    check("err_latency", cyc - last_strobe[i], ToCyc + 1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        send_en   = '0;
        cmdcode   = '0;
        para_list = '0;
        para_num  = '0;
        for (int i = 0; i < 2; i++) begin
            trig[i] = 0;
            cnt[i] = 0;
            nstrobe[i] = 0;
            limit[i] = 0;
            last_strobe[i] = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_tx_en", 32'(tx_en[i]), 0);
            check("rst_tx_data", 32'(tx_data[i]), 0);
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_done", 32'(done[i]), 0);
            check("rst_err", 32'(err[i]), 0);
        end
        rst_n = 1'b1;

        // Full 4-parameter frame with fixed tail.
        send(0, 8'h12, 32'h44332211, 3'd4, Full);
        check("accept_busy", 32'(busy[0]), 1);
        check("accept_strobe", 32'(tx_en[0]), 1);
        wait_frame(0);

        // XOR checksum.
        send(1, 8'ha5, 32'h00003c0f, 3'd2, Full);
        wait_frame(1);
        check("xor_check_held", 32'(tx_data[1]), 32'h95);

        // N=0 and clamped N on both variants.
        send(0, 8'h01, 32'h00000000, 3'd0, Full);
        wait_frame(0);
        check("tail_held", 32'(tx_data[0]), 32'hbc);
        send(0, 8'h77, 32'hddccbbaa, 3'd6, Full);
        wait_frame(0);
        send(1, 8'h01, 32'hffffffff, 3'd0, Full);
        wait_frame(1);
        send(1, 8'h5a, 32'h87654321, 3'd7, Full);
        wait_frame(1);

        // Requests mid-frame and in the done cycle are dropped.
        send(0, 8'h33, 32'h0badf00d, 3'd3, Full);
        repeat (25) @(negedge clk);
        send(0, 8'hee, 32'hffffffff, 3'd4, Ignore);
        n = 0;
        while (!done[0] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        send_en[0] = 1'b1;
        cmdcode[0] = 8'hee;
        @(negedge clk);
        send_en[0] = 1'b0;
        check("post_done_busy", 32'(busy[0]), 0);
        repeat (20) @(negedge clk);
        check("no_queued_frame", 32'(busy[0]), 0);
        check("no_extra_bytes", qsize(0), 0);

        // Timeout: only the first two bytes are acknowledged.
        limit[0] = 2;
        push(0, 32'h40);
        push(0, 32'h05);
        push(0, 32'h12);
        push(0, TokErr);
        send(0, 8'h12, 32'h44332211, 3'd4, AccOnly);
        wait_frame(0);
        limit[0] = 0;
        send(0, 8'h12, 32'h44332211, 3'd4, Full);
        wait_frame(0);

        // Reset while PARA bytes are in flight.
        send(0, 8'hc3, 32'h11223344, 3'd4, Full);
        n = 0;
        while (nstrobe[0] < 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx_en", 32'(tx_en[0]), 0);
        check("midrst_tx_data", 32'(tx_data[0]), 0);
        check("midrst_busy", 32'(busy[0]), 0);
        check("midrst_done", 32'(done[0]), 0);
        check("midrst_err", 32'(err[0]), 0);
        q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(busy[0]), 0);
        send(0, 8'hc3, 32'h11223344, 3'd4, Full);
        wait_frame(0);

        repeat (5) @(negedge clk);
        check("final_q0", qsize(0), 0);
        check("final_q1", qsize(1), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
